// File: rtl/cont_pkg.sv
// Shared definitions for the 4-digit BCD counter sequencer: state encoding,
// BCD digit limit and state width.
package cont_pkg;

    localparam int ST_W = 2;

    // Largest legal BCD digit value; 9999 is all four digits at this value.
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [ST_W-1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/tick_gen.sv
// Prescaler for the count sequencer. Counts clock cycles while run is high
// and emits a registered one-cycle tick every PRESCALE counted cycles.
// zero forces the count back to 0; with run low and zero low the count holds,
// which is what lets a paused sequence resume mid-period.
module tick_gen #(
    parameter int PRESCALE = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic zero,
    output logic tick
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] count_reg;
    logic             tick_reg;

    // Prescale counter with terminal-count tick; tick is low unless just wrapped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg <= '0;
            tick_reg  <= 1'b0;
        end else begin
            tick_reg <= 1'b0;
            if (zero) begin
                count_reg <= '0;
            end else if (run) begin
                if (count_reg == LAST) begin
                    count_reg <= '0;
                    tick_reg  <= 1'b1;
                end else begin
                    count_reg <= count_reg + CNT_W'(1);
                end
            end
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/cont_9999_ctrl.sv
// Run/pause/clear sequencer for a 4-digit BCD counter. Front-panel requests
// are edge-detected and turned into single-cycle cnt_en / cnt_clr pulses,
// paced by tick_gen. The returned digits are compared against an optional
// target and against 9999 (when not wrapping) to stop the sequence.
module cont_9999_ctrl
    import cont_pkg::*;
#(
    parameter int PRESCALE = 50_000_000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stop,
    input  logic            clear,
    input  logic            mode_wrap,
    input  logic            target_en,
    input  logic [3:0]      target0,
    input  logic [3:0]      target1,
    input  logic [3:0]      target2,
    input  logic [3:0]      target3,
    input  logic [3:0]      cont0,
    input  logic [3:0]      cont1,
    input  logic [3:0]      cont2,
    input  logic [3:0]      cont3,
    output logic            cnt_en,
    output logic            cnt_clr,
    output logic            running,
    output logic            done,
    output logic [ST_W-1:0] state
);

    // Request bit positions: 0=start, 1=stop, 2=clear.
    logic [2:0] req_in;
    logic [2:0] req_prev_reg;
    logic [2:0] req_edge;
    logic       start_e;
    logic       stop_e;
    logic       clear_e;

    logic [3:0] cont_d [4];
    logic [3:0] tgt_d  [4];
    logic [3:0] tgt_eq;
    logic [3:0] max_eq;
    logic       hit;

    state_t state_reg;
    state_t state_next;
    logic   cnt_clr_reg;
    logic   cnt_clr_next;
    logic   running_reg;
    logic   done_reg;
    logic   run_tick;
    logic   zero_tick;

    assign req_in = {clear, stop, start};

    // Edge-detect history; preset to 1 so a request held through reset is not seen as an edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_prev_reg <= '1;
        end else begin
            req_prev_reg <= req_in;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_edge
            assign req_edge[gi] = req_in[gi] & ~req_prev_reg[gi];
        end
    endgenerate

    assign start_e = req_edge[0];
    assign stop_e  = req_edge[1];
    assign clear_e = req_edge[2];

    assign cont_d[0] = cont0;
    assign cont_d[1] = cont1;
    assign cont_d[2] = cont2;
    assign cont_d[3] = cont3;
    assign tgt_d[0]  = target0;
    assign tgt_d[1]  = target1;
    assign tgt_d[2]  = target2;
    assign tgt_d[3]  = target3;

    // Literal per-digit compares: non-BCD digit codes never look like 9999.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign tgt_eq[gi] = (cont_d[gi] == tgt_d[gi]);
            assign max_eq[gi] = (cont_d[gi] == BCD_MAX);
        end
    endgenerate

    assign hit = (target_en & (&tgt_eq)) | (~mode_wrap & (&max_eq));

    // Next-state and pulse decode; clear beats stop beats start in every state.
    always_comb begin
        state_next   = state_reg;
        cnt_clr_next = 1'b0;
        run_tick     = 1'b0;
        zero_tick    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (clear_e) begin
                    cnt_clr_next = 1'b1;
                end else if (stop_e) begin
                    state_next = IDLE;
                end else if (start_e) begin
                    state_next = RUN;
                    zero_tick  = 1'b1;
                end
            end
            RUN: begin
                if (clear_e) begin
                    cnt_clr_next = 1'b1;
                    state_next   = IDLE;
                    zero_tick    = 1'b1;
                end else if (stop_e) begin
                    state_next = PAUSE;
                end else if (hit) begin
                    // Stop before another pulse can be issued on the terminal value.
                    state_next = DONE;
                end else begin
                    run_tick = 1'b1;
                end
            end
            PAUSE: begin
                if (clear_e) begin
                    cnt_clr_next = 1'b1;
                    state_next   = IDLE;
                    zero_tick    = 1'b1;
                end else if (stop_e) begin
                    state_next = PAUSE;
                end else if (start_e) begin
                    // Prescaler is left alone so the interrupted period resumes.
                    state_next = RUN;
                end
            end
            DONE: begin
                if (clear_e) begin
                    cnt_clr_next = 1'b1;
                    state_next   = IDLE;
                    zero_tick    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and registered status outputs, all updated on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            cnt_clr_reg <= 1'b0;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_clr_reg <= cnt_clr_next;
            running_reg <= (state_next == RUN);
            done_reg    <= (state_next == DONE);
        end
    end

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .run   (run_tick),
        .zero  (zero_tick),
        .tick  (cnt_en)
    );

    assign cnt_clr = cnt_clr_reg;
    assign running = running_reg;
    assign done    = done_reg;
    assign state   = state_reg;

endmodule

// File: tb/tb_cont_9999_ctrl.sv
// Directed bench for cont_9999_ctrl with PRESCALE=4 and a behavioural BCD
// counter closing the loop from cnt_en/cnt_clr back to cont0..3.
module tb_cont_9999_ctrl;

    localparam int PRESCALE = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       clear;
    logic       mode_wrap;
    logic       target_en;
    logic [3:0] target0;
    logic [3:0] target1;
    logic [3:0] target2;
    logic [3:0] target3;
    logic [3:0] cont0;
    logic [3:0] cont1;
    logic [3:0] cont2;
    logic [3:0] cont3;
    logic       cnt_en;
    logic       cnt_clr;
    logic       running;
    logic       done;
    logic [1:0] state;

    logic [15:0] mval;
    logic [15:0] ld_val;
    logic        ld_en;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cont_9999_ctrl #(
        .PRESCALE (PRESCALE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .mode_wrap (mode_wrap),
        .target_en (target_en),
        .target0   (target0),
        .target1   (target1),
        .target2   (target2),
        .target3   (target3),
        .cont0     (cont0),
        .cont1     (cont1),
        .cont2     (cont2),
        .cont3     (cont3),
        .cnt_en    (cnt_en),
        .cnt_clr   (cnt_clr),
        .running   (running),
        .done      (done),
        .state     (state)
    );

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (r[i*4 +: 4] == 4'd9) begin
                r[i*4 +: 4] = 4'd0;
            end else begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                break;
            end
        end
        return r;
    endfunction

    // Counter model: updates on the edge that samples cnt_en / cnt_clr.
    always @(posedge clk) begin
        if (reset !== 1'b1)   mval <= 16'h0000;
        else if (ld_en)       mval <= ld_val;
        else if (cnt_clr)     mval <= 16'h0000;
        else if (cnt_en)      mval <= bcd_inc(mval);
    end

    assign {cont3, cont2, cont1, cont0} = mval;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        $display("vec %0d %s obs=%0h exp=%0h", vectors, tag, obs, exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int guard;
        int last_pulse;
        int done_cyc;

        reset = 1'b0; start = 1'b1; stop = 1'b0; clear = 1'b0;
        mode_wrap = 1'b1; target_en = 1'b0;
        target0 = 4'd0; target1 = 4'd0; target2 = 4'd0; target3 = 4'd0;
        ld_en = 1'b0; ld_val = 16'h0000;

        // Reset with start held high.
        cyc(3);
        check("rst_state",   32'(state),   0);
        check("rst_cnt_en",  32'(cnt_en),  0);
        check("rst_cnt_clr", 32'(cnt_clr), 0);
        check("rst_running", 32'(running), 0);
        check("rst_done",    32'(done),    0);
        reset = 1'b1;
        cyc(2);
        check("rel_state",   32'(state),   0);
        check("rel_running", 32'(running), 0);
        check("rel_cnt_en",  32'(cnt_en),  0);
        start = 1'b0;
        cyc(1);

        // Free run from 0000: first pulse at +5, then every 4.
        start = 1'b1;
        cyc(1);
        check("run_state",   32'(state),   1);
        check("run_running", 32'(running), 1);
        check("run_cnt_en0", 32'(cnt_en),  0);
        start = 1'b0;
        cyc(3);
        check("run_pre_first", 32'(cnt_en), 0);
        cyc(1);
        check("run_first",     32'(cnt_en), 1);
        cyc(1);
        check("run_one_wide",  32'(cnt_en), 0);
        cyc(3);
        check("run_second",    32'(cnt_en), 1);

        // Stop with prescaler at 2, then resume: pulse 2 cycles after re-entry.
        cyc(2);
        stop = 1'b1;
        cyc(1);
        check("pause_state",   32'(state),   2);
        check("pause_running", 32'(running), 0);
        stop = 1'b0;
        cyc(3);
        check("pause_hold_en", 32'(cnt_en), 0);
        check("pause_hold_st", 32'(state),  2);
        start = 1'b1;
        cyc(1);
        check("resume_state", 32'(state), 1);
        start = 1'b0;
        cyc(1);
        check("resume_en_early", 32'(cnt_en), 0);
        cyc(1);
        check("resume_en",       32'(cnt_en), 1);

        // start+stop together in RUN: stop wins.
        start = 1'b1; stop = 1'b1;
        cyc(1);
        check("startstop_state", 32'(state), 2);
        start = 1'b0; stop = 1'b0;

        // Clear in PAUSE.
        clear = 1'b1;
        cyc(1);
        check("clr_pause_state", 32'(state),   0);
        check("clr_pause_pulse", 32'(cnt_clr), 1);
        clear = 1'b0;
        cyc(1);
        check("clr_pause_width", 32'(cnt_clr), 0);

        // Clear and start together in IDLE.
        clear = 1'b1; start = 1'b1;
        cyc(1);
        check("clr_idle_pulse", 32'(cnt_clr), 1);
        check("clr_idle_state", 32'(state),   0);
        clear = 1'b0; start = 1'b0;
        cyc(1);
        check("clr_idle_width", 32'(cnt_clr), 0);
        check("clr_idle_stay",  32'(state),   0);

        // Clear in RUN.
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
        clear = 1'b1;
        cyc(1);
        check("clr_run_state", 32'(state),   0);
        check("clr_run_pulse", 32'(cnt_clr), 1);
        check("clr_run_en",    32'(cnt_en),  0);
        clear = 1'b0;
        cyc(1);
        check("clr_run_width", 32'(cnt_clr), 0);

        // Target 0012: exactly 12 pulses, DONE two cycles after the 12th.
        target_en = 1'b1;
        target3 = 4'd0; target2 = 4'd0; target1 = 4'd1; target0 = 4'd2;
        start = 1'b1;
        cyc(1);
        check("tgt_run", 32'(state), 1);
        start = 1'b0;
        pulses = 0; guard = 0; last_pulse = 0;
        while (state !== 2'b11 && guard < 200) begin
            cyc(1);
            guard++;
            if (cnt_en === 1'b1) begin
                pulses++;
                last_pulse = guard;
            end
        end
        done_cyc = guard;
        check("tgt_timeout", 32'(guard < 200), 1);
        check("tgt_pulses",  pulses, 12);
        check("tgt_latency", done_cyc - last_pulse, 2);
        check("tgt_done",    32'(done),    1);
        check("tgt_running", 32'(running), 0);
        pulses = 0;
        start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            start = 1'b0;
            if (cnt_en === 1'b1) pulses++;
        end
        check("tgt_no_13th", pulses, 0);
        check("tgt_stay",    32'(state), 3);

        // Clear in DONE.
        clear = 1'b1;
        cyc(1);
        check("clr_done_state", 32'(state),   0);
        check("clr_done_pulse", 32'(cnt_clr), 1);
        check("clr_done_done",  32'(done),    0);
        clear = 1'b0;
        cyc(1);
        check("clr_done_width", 32'(cnt_clr), 0);

        // 9998 with mode_wrap=0: one pulse, then DONE at 9999.
        target_en = 1'b0; mode_wrap = 1'b0;
        ld_val = 16'h9998; ld_en = 1'b1;
        cyc(1);
        ld_en = 1'b0;
        start = 1'b1;
        cyc(1);
        check("max_run", 32'(state), 1);
        start = 1'b0;
        cyc(3);
        check("max_pre_en", 32'(cnt_en), 0);
        cyc(1);
        check("max_en",     32'(cnt_en), 1);
        cyc(1);
        check("max_still_run", 32'(state), 1);
        cyc(1);
        check("max_done_state", 32'(state),   3);
        check("max_done",       32'(done),    1);
        check("max_no_en",      32'(cnt_en),  0);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        cyc(1);

        // 9998 with mode_wrap=1: rolls through 9999 to 0000 and keeps running.
        mode_wrap = 1'b1;
        ld_val = 16'h9998; ld_en = 1'b1;
        cyc(1);
        ld_en = 1'b0;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(4);
        check("wrap_en1", 32'(cnt_en), 1);
        cyc(4);
        check("wrap_en2",   32'(cnt_en), 1);
        check("wrap_state", 32'(state),  1);
        cyc(2);
        check("wrap_after", 32'(state),   1);
        check("wrap_run",   32'(running), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
